quad_step_driver: RTL

Quadrature-encoder front end that drives the control side of the 4-bit up/down counter (`load`, `up_down`, `enable`, `d_in`). It synchronises raw encoder phases A/B and an index mark, and decodes Gray-code transitions into single-cycle count-up or count-down strobes. It turns the index edge into a preset load and flags illegal phase jumps. It sits between the board pins and the counter, which supplies the position register.

---
 rtl/qdec_pkg.sv | 49 ++++
 rtl/sync_ff.sv | 25 ++
 rtl/quad_step_driver.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/qdec_pkg.sv
// Shared types and constants for the quadrature step driver: FSM states,
// decoded step kinds, Gray-step encodings and the error counter ceiling.
package qdec_pkg;

    typedef enum logic [1:0] {
        S_PRIME = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } qdec_state_t;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_FWD     = 2'd1,
        STEP_REV     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } qdec_step_t;

    // Forward Gray steps keyed on {previous AB, current AB}: 00->01->11->10->00
    localparam logic [3:0] FWD_00_01 = 4'b00_01;
    localparam logic [3:0] FWD_01_11 = 4'b01_11;
    localparam logic [3:0] FWD_11_10 = 4'b11_10;
    localparam logic [3:0] FWD_10_00 = 4'b10_00;

    // Reverse Gray steps keyed on {previous AB, current AB}: 00->10->11->01->00
    localparam logic [3:0] REV_00_10 = 4'b00_10;
    localparam logic [3:0] REV_10_11 = 4'b10_11;
    localparam logic [3:0] REV_11_01 = 4'b11_01;
    localparam logic [3:0] REV_01_00 = 4'b01_00;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Classify one sampled AB transition; a change of both bits is illegal.
    function automatic qdec_step_t qdec_decode(input logic [1:0] prevAb,
                                               input logic [1:0] curAb);
        qdec_step_t result;
        result = STEP_ILLEGAL;
        if (prevAb == curAb) begin
            result = STEP_NONE;
        end else begin
            case ({prevAb, curAb})
                FWD_00_01, FWD_01_11, FWD_11_10, FWD_10_00: result = STEP_FWD;
                REV_00_10, REV_10_11, REV_11_01, REV_01_00: result = STEP_REV;
                default:                                    result = STEP_ILLEGAL;
            endcase
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser for an asynchronous board input.
// Every stage clears to 0 on reset so the pipeline starts from a known level.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_pipe;

    // Shift the raw input through the flop chain, oldest sample at the top bit.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= {r_pipe[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_pipe[STAGES-1];

endmodule

// File: rtl/quad_step_driver.sv
// Quadrature encoder front end: synchronises phases A/B and the index mark,
// decodes Gray transitions into one-cycle count strobes for an up/down
// counter, turns an index rising edge into a preset load, and latches a
// sticky fault on any transition that changes both phases at once.
module quad_step_driver
    import qdec_pkg::*;
#(
    parameter int               SYNC_STAGES = 2,
    parameter int               CNT_W       = 4,
    parameter logic [CNT_W-1:0] HOME_VAL    = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enc_a,
    input  logic             i_enc_b,
    input  logic             i_enc_idx,
    input  logic             i_clr_err,
    output logic             o_load,
    output logic             o_up_down,
    output logic             o_enable,
    output logic [CNT_W-1:0] o_d_in,
    output logic             o_err,
    output logic [7:0]       o_err_cnt
);

    localparam int                 PRIME_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES);

    logic             w_aSync;
    logic             w_bSync;
    logic             w_idxSync;
    logic [1:0]       w_abSync;
    logic             w_idxRise;
    qdec_step_t       w_step;

    logic [1:0]       r_abQ;
    logic             r_idxQ;

    qdec_state_t      r_state;
    qdec_state_t      w_stateNext;
    logic [PRIME_W-1:0] r_primeCnt;
    logic [PRIME_W-1:0] w_primeCntNext;

    logic             r_load;
    logic             r_enable;
    logic             r_upDown;
    logic             r_err;
    logic [7:0]       r_errCnt;
    logic             w_loadNext;
    logic             w_enableNext;
    logic             w_upDownNext;
    logic             w_errNext;
    logic [7:0]       w_errCntNext;

    sync_ff #(.STAGES(SYNC_STAGES)) u_syncA (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_enc_a),
        .o_q     (w_aSync)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_syncB (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_enc_b),
        .o_q     (w_bSync)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_syncIdx (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_enc_idx),
        .o_q     (w_idxSync)
    );

    assign w_abSync  = {w_aSync, w_bSync};
    assign w_idxRise = w_idxSync & ~r_idxQ;
    assign w_step    = qdec_decode(r_abQ, w_abSync);

    // Keep the previous synchronised AB pair and index level in every state,
    // so priming and fault recovery always compare against a fresh sample.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_abQ  <= 2'b00;
            r_idxQ <= 1'b0;
        end else begin
            r_abQ  <= w_abSync;
            r_idxQ <= w_idxSync;
        end
    end

    // State register and priming counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_PRIME;
            r_primeCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_primeCnt <= w_primeCntNext;
        end
    end

    // Next-state and next-output decode; an index load wins over a step.
    always_comb begin
        w_stateNext    = r_state;
        w_primeCntNext = r_primeCnt;
        w_loadNext     = 1'b0;
        w_enableNext   = 1'b0;
        w_upDownNext   = r_upDown;
        w_errNext      = r_err;
        w_errCntNext   = r_errCnt;

        unique case (r_state)
            S_PRIME: begin
                if (r_primeCnt == PRIME_DONE) begin
                    w_stateNext    = S_TRACK;
                    w_primeCntNext = '0;
                end else begin
                    w_primeCntNext = r_primeCnt + 1'b1;
                end
            end

            S_TRACK: begin
                w_loadNext = w_idxRise;
                if (w_step == STEP_ILLEGAL) begin
                    w_errNext   = 1'b1;
                    w_stateNext = S_FAULT;
                    if (r_errCnt != ERR_CNT_MAX) begin
                        w_errCntNext = r_errCnt + 8'd1;
                    end
                end else if (!w_idxRise && (w_step != STEP_NONE)) begin
                    w_enableNext = 1'b1;
                    w_upDownNext = (w_step == STEP_FWD);
                end
            end

            S_FAULT: begin
                if (i_clr_err) begin
                    w_stateNext    = S_PRIME;
                    w_primeCntNext = '0;
                    w_errNext      = 1'b0;
                end
            end

            default: begin
                w_stateNext    = S_PRIME;
                w_primeCntNext = '0;
            end
        endcase
    end

    // Registered outputs toward the counter and the fault flags.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_load   <= 1'b0;
            r_enable <= 1'b0;
            r_upDown <= 1'b1;
            r_err    <= 1'b0;
            r_errCnt <= 8'd0;
        end else begin
            r_load   <= w_loadNext;
            r_enable <= w_enableNext;
            r_upDown <= w_upDownNext;
            r_err    <= w_errNext;
            r_errCnt <= w_errCntNext;
        end
    end

    assign o_load    = r_load;
    assign o_enable  = r_enable;
    assign o_up_down = r_upDown;
    assign o_err     = r_err;
    assign o_err_cnt = r_errCnt;
    assign o_d_in    = HOME_VAL;

endmodule
